// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared definitions for the memory-mapped UART transmitter.
//               Holds register offsets on addr[1:0], STATUS/CTRL bit
//               positions and the transmit FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

  // Register offsets on addr[1:0]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_ACTIVE  = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;  // 3-bit saturating FIFO count

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous byte FIFO for the UART transmitter. Pointers carry
//               one extra wrap bit so that full and empty are distinguishable
//               when the index bits match.
// Ports       : clk_i, rst_ni   - clock, async active-low reset
//               push_i, wdata_i - write request and byte
//               pop_i, rdata_o  - read request and head byte (combinational)
//               flush_i         - discard all entries (overrides push/pop)
//               full_o, empty_o, count_o - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  input  logic          flush_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [PW-1:0] count_o
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is still accepted when a pop frees the head slot
  // on the same edge; the popped byte is read before the slot is rewritten.
  assign w_pop_ok  = pop_i && !empty_o;
  assign w_push_ok = push_i && (!full_o || w_pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter on an 8-bit CPU bus.
//               TXDATA pushes into a FIFO, STATUS reports occupancy/overflow,
//               BAUDDIV sets the bit period (value+1 clocks), CTRL holds
//               enable and a self-clearing flush.
// Ports       : clk_i, rst_ni      - clock, async active-low reset
//               en_i, rd_i, wr_i   - chip select and bus strobes
//               addr_i             - bus address, only [1:0] decoded
//               data_io            - bidirectional bus data
//               txd_o              - serial output, idles high
//               tx_busy_o          - frame on line or FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
  import cpu_bus_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,   // power of two, >= 2
  parameter logic [7:0] BAUD_DIV_RST = 8'd15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [12:0] addr_i,
  inout  wire  [7:0]  data_io,
  output logic        txd_o,
  output logic        tx_busy_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [7:0] baud_cnt_q, baud_cnt_d;
  logic [7:0] frame_div_q, frame_div_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       txd_q, txd_d;
  logic       busy_q;
  logic [7:0] baud_div_q;
  logic       ctrl_en_q;
  logic       ovf_q, ovf_d;

  logic          w_wr, w_rd_drive, w_status_rd;
  logic          w_push_req, w_push_ok, w_pop, w_flush;
  logic          w_wr_baud, w_wr_ctrl;
  logic          w_fifo_full, w_fifo_empty;
  logic [7:0]    w_fifo_rdata;
  logic [CW-1:0] w_fifo_count;
  logic [31:0]   w_cnt_wide;
  logic [2:0]    w_cnt_sat;
  logic          w_fifo_nonempty_next;
  logic          w_can_start, w_tick;
  logic [7:0]    w_status, w_ctrl_rd, w_rdata;
  logic          w_unused_addr;

  assign w_unused_addr = ^addr_i[12:2];

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  assign w_wr        = en_i && wr_i;
  assign w_rd_drive  = en_i && rd_i && !wr_i;
  assign w_status_rd = en_i && rd_i && (addr_i[1:0] == REG_STATUS);
  assign w_wr_baud   = w_wr && (addr_i[1:0] == REG_BAUDDIV);
  assign w_wr_ctrl   = w_wr && (addr_i[1:0] == REG_CTRL);
  assign w_flush     = w_wr_ctrl && data_io[CTRL_FLUSH];
  // Flush beats a coincident push: the byte is silently discarded.
  assign w_push_req  = w_wr && (addr_i[1:0] == REG_TXDATA) && !w_flush;
  assign w_push_ok   = w_push_req && (!w_fifo_full || w_pop);

  uart_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push_req),
    .wdata_i (data_io),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_rdata),
    .flush_i (w_flush),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  assign w_cnt_wide = 32'(w_fifo_count);
  assign w_cnt_sat  = (w_cnt_wide > 32'd7) ? 3'd7 : w_cnt_wide[2:0];

  // Occupancy after this edge, used to register tx_busy without a lag.
  assign w_fifo_nonempty_next = !w_flush &&
                                (w_push_ok ||
                                 (w_fifo_count > CW'(1)) ||
                                 ((w_fifo_count == CW'(1)) && !w_pop));

  // --------------------------------------------------------------------------
  // Read mux and tri-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_status                          = '0;
    w_status[STAT_FULL]               = w_fifo_full;
    w_status[STAT_EMPTY]              = w_fifo_empty;
    w_status[STAT_ACTIVE]             = (state_q != ST_IDLE);
    w_status[STAT_OVF]                = ovf_q;
    w_status[STAT_CNT_LSB +: 3]       = w_cnt_sat;
    w_ctrl_rd                         = '0;
    w_ctrl_rd[CTRL_EN]                = ctrl_en_q;
    case (addr_i[1:0])
      REG_STATUS:  w_rdata = w_status;
      REG_BAUDDIV: w_rdata = baud_div_q;
      REG_CTRL:    w_rdata = w_ctrl_rd;
      default:     w_rdata = 8'h00;
    endcase
  end

  assign data_io = w_rd_drive ? w_rdata : 8'hzz;

  // --------------------------------------------------------------------------
  // Overflow: flush clears, a dropped push sets, a STATUS read clears.
  // --------------------------------------------------------------------------
  always_comb begin
    ovf_d = ovf_q;
    if (w_flush)                                ovf_d = 1'b0;
    else if (w_push_req && !w_push_ok)          ovf_d = 1'b1;
    else if (w_status_rd)                       ovf_d = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  assign w_can_start = ctrl_en_q && !w_fifo_empty && !w_flush;
  assign w_tick      = (baud_cnt_q == frame_div_q);

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q + 8'd1;
    frame_div_d = frame_div_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    txd_d       = txd_q;
    w_pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        txd_d      = 1'b1;
        if (w_can_start) begin
          w_pop       = 1'b1;
          state_d     = ST_START;
          shift_d     = w_fifo_rdata;
          frame_div_d = baud_div_q;
          txd_d       = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = ST_DATA;
          txd_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (w_can_start) begin
            w_pop       = 1'b1;
            state_d     = ST_START;
            shift_d     = w_fifo_rdata;
            frame_div_d = baud_div_q;
            txd_d       = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      frame_div_q <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      baud_div_q  <= BAUD_DIV_RST;
      ctrl_en_q   <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      frame_div_q <= frame_div_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      txd_q       <= txd_d;
      busy_q      <= (state_d != ST_IDLE) || w_fifo_nonempty_next;
      ovf_q       <= ovf_d;
      if (w_wr_baud) baud_div_q <= data_io;
      if (w_wr_ctrl) ctrl_en_q  <= data_io[CTRL_EN];
    end
  end

  assign txd_o     = txd_q;
  assign tx_busy_o = busy_q;

endmodule
`default_nettype wire
